// File: rtl/exec_if.sv
// Execute-stage bus: issue side (start/op/operands/destination) and
// write-back side (busy/we/wr_addr/wr_data).
//   master : controller / register-file side, drives the issue signals
//   slave  : exec_unit, drives busy and the write-back triple
interface exec_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [ADDR_W-1:0] dst_addr;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  modport master (
    output start, op, a, b, dst_addr,
    input  busy, we, wr_addr, wr_data
  );

  modport slave (
    input  start, op, a, b, dst_addr,
    output busy, we, wr_addr, wr_data
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ADD/SUB/PASSB and a sequential signed
// fractional multiply (one shift-add step per cycle, floor + saturate).
//   clk     : system clock, rising edge
//   n_reset : synchronous active-low reset
//   bus     : exec_if slave (start, op, a, b, dst_addr -> busy, we,
//             wr_addr, wr_data)
module exec_unit #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned FRAC   = 7
) (
  input  logic   clk,
  input  logic   n_reset,
  exec_if.slave  bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned OVF_W = PW - WIDTH + 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MULF = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t                   state, state_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic signed [PW-1:0]     acc, acc_n;
  logic signed [PW-1:0]     mcand, mcand_n;
  logic [WIDTH-1:0]         mplier, mplier_n;
  logic [ADDR_W-1:0]        dst_q, dst_n;
  logic                     busy_q, busy_n;
  logic                     we_q, we_n;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_n;
  logic [WIDTH-1:0]         wr_data_q, wr_data_n;

  logic signed [PW-1:0]     addend;
  logic signed [PW-1:0]     shifted;
  logic [WIDTH-1:0]         sat;
  logic [WIDTH-1:0]         alu;

  assign bus.busy    = busy_q;
  assign bus.we      = we_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  // Single-cycle ALU result
  always_comb begin
    alu = bus.b;
    case (bus.op)
      OP_ADD:  alu = bus.a + bus.b;
      OP_SUB:  alu = bus.a - bus.b;
      OP_PASS: alu = bus.b;
      default: alu = bus.b;
    endcase
  end

  // Floor (arithmetic shift) then clamp to the signed WIDTH range
  always_comb begin
    shifted = acc >>> FRAC;
    if (shifted[PW-1:WIDTH-1] == {OVF_W{shifted[PW-1]}})
      sat = shifted[WIDTH-1:0];
    else if (shifted[PW-1])
      sat = {1'b1, {(WIDTH-1){1'b0}}};
    else
      sat = {1'b0, {(WIDTH-1){1'b1}}};
  end

  // Partial product for this step; the multiplier MSB carries negative weight
  assign addend = mplier[0] ? mcand : '0;

  // Next-state and output logic
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    acc_n     = acc;
    mcand_n   = mcand;
    mplier_n  = mplier;
    dst_n     = dst_q;
    busy_n    = busy_q;
    we_n      = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MULF) begin
            mcand_n  = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
            mplier_n = bus.b;
            acc_n    = '0;
            cnt_n    = '0;
            dst_n    = bus.dst_addr;
            busy_n   = 1'b1;
            state_n  = MUL;
          end else begin
            we_n      = 1'b1;
            wr_addr_n = bus.dst_addr;
            wr_data_n = alu;
          end
        end
      end
      MUL: begin
        acc_n    = (cnt == LAST) ? (acc - addend) : (acc + addend);
        mcand_n  = mcand <<< 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + CNT_W'(1);
        if (cnt == LAST)
          state_n = FIN;
      end
      FIN: begin
        we_n      = 1'b1;
        busy_n    = 1'b0;
        wr_addr_n = dst_q;
        wr_data_n = sat;
        state_n   = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      dst_q     <= '0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      acc       <= acc_n;
      mcand     <= mcand_n;
      mplier    <= mplier_n;
      dst_q     <= dst_n;
      busy_q    <= busy_n;
      we_q      <= we_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU ops, MULF timing and corners,
// start-while-busy rejection, and reset during a multiply.
module tb_exec_unit;

  logic clk;
  logic n_reset;
  int   n_checks;
  int   n_errors;
  int   we_seen;

  exec_if #(.WIDTH(8), .ADDR_W(3)) bus ();

  exec_unit #(.WIDTH(8), .ADDR_W(3), .FRAC(7)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] dst);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.dst_addr = dst;
  endtask

  // MULF: busy over MUL+FIN, we exactly 9 edges after the start edge
  task automatic mulf(input logic [7:0] a, input logic [7:0] b, input logic [2:0] dst,
                      input logic [7:0] exp, input bit interfere);
    issue(2'b10, a, b, dst);
    tick();
    bus.start = 1'b0;
    check("mulf_busy_e0", 16'(bus.busy), 16'h1);
    for (int i = 1; i <= 8; i++) begin
      if (interfere && i == 2) issue(2'b00, 8'h11, 8'h22, 3'd7);
      if (interfere && i == 3) bus.start = 1'b0;
      tick();
      check($sformatf("mulf_busy_e%0d", i), 16'(bus.busy), 16'h1);
      check($sformatf("mulf_we_e%0d", i), 16'(bus.we), 16'h0);
    end
    tick();
    check("mulf_we", 16'(bus.we), 16'h1);
    check("mulf_busy_fin", 16'(bus.busy), 16'h0);
    check("mulf_addr", 16'(bus.wr_addr), 16'(dst));
    check("mulf_data", 16'(bus.wr_data), 16'(exp));
    tick();
    check("mulf_we_after", 16'(bus.we), 16'h0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    n_reset      = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.a        = 8'h00;
    bus.b        = 8'h00;
    bus.dst_addr = 3'd0;

    // Reset, with start asserted to show reset overrides it
    tick();
    issue(2'b00, 8'h01, 8'h01, 3'd1);
    tick();
    bus.start = 1'b0;
    check("rst_busy", 16'(bus.busy), 16'h0);
    check("rst_we", 16'(bus.we), 16'h0);
    check("rst_addr", 16'(bus.wr_addr), 16'h0);
    check("rst_data", 16'(bus.wr_data), 16'h0);
    n_reset = 1'b1;
    tick();

    // ADD 100+100 = 0xC8
    issue(2'b00, 8'd100, 8'd100, 3'd2);
    tick();
    bus.start = 1'b0;
    check("add_we", 16'(bus.we), 16'h1);
    check("add_addr", 16'(bus.wr_addr), 16'h2);
    check("add_data", 16'(bus.wr_data), 16'hC8);
    tick();
    check("add_we_after", 16'(bus.we), 16'h0);
    check("add_data_hold", 16'(bus.wr_data), 16'hC8);

    // SUB 5-10 = 0xFB then PASSB 0x3C back to back
    issue(2'b01, 8'd5, 8'd10, 3'd3);
    tick();
    check("sub_we", 16'(bus.we), 16'h1);
    check("sub_addr", 16'(bus.wr_addr), 16'h3);
    check("sub_data", 16'(bus.wr_data), 16'hFB);
    issue(2'b11, 8'h99, 8'h3C, 3'd4);
    tick();
    bus.start = 1'b0;
    check("pass_we", 16'(bus.we), 16'h1);
    check("pass_addr", 16'(bus.wr_addr), 16'h4);
    check("pass_data", 16'(bus.wr_data), 16'h3C);
    tick();
    check("pass_we_after", 16'(bus.we), 16'h0);

    // ADD wrap: 0xF0 + 0x20 = 0x10
    issue(2'b00, 8'hF0, 8'h20, 3'd6);
    tick();
    bus.start = 1'b0;
    check("add_wrap", 16'(bus.wr_data), 16'h10);

    // MULF: 0.5*0.5 and the corners
    mulf(8'h40, 8'h40, 3'd5, 8'h20, 1'b0);
    mulf(8'h80, 8'h80, 3'd1, 8'h7F, 1'b0);
    mulf(8'hFF, 8'h01, 3'd2, 8'hFF, 1'b0);
    mulf(8'h80, 8'h7F, 3'd3, 8'h81, 1'b0);
    mulf(8'hC0, 8'h40, 3'd4, 8'hE0, 1'b0);

    // Start while busy (ADD on other operands) is ignored
    mulf(8'h60, 8'h20, 3'd6, 8'h18, 1'b1);

    // Reset after four multiply iterations aborts cleanly
    issue(2'b10, 8'h40, 8'h40, 3'd5);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    check("abort_busy", 16'(bus.busy), 16'h0);
    check("abort_we", 16'(bus.we), 16'h0);
    check("abort_addr", 16'(bus.wr_addr), 16'h0);
    check("abort_data", 16'(bus.wr_data), 16'h0);
    we_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.we) we_seen++;
    end
    check("abort_no_we", 16'(we_seen), 16'h0);

    // Normal operation resumes
    issue(2'b00, 8'd3, 8'd4, 3'd1);
    tick();
    bus.start = 1'b0;
    check("post_we", 16'(bus.we), 16'h1);
    check("post_addr", 16'(bus.wr_addr), 16'h1);
    check("post_data", 16'(bus.wr_data), 16'h07);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
